// File: rtl/jtag_tap_param_if.sv
// JTAG serial pin bundle (TMS/TDI in, TDO/TDO_EN out) between a tester-side driver and the TAP.
// Latency: none, wires only.
// Backpressure: none; the TAP protocol is paced entirely by TCK.
// Ports: master = pin driver (drives TMS/TDI, observes TDO/TDO_EN);
//        slave  = TAP (observes TMS/TDI, drives TDO/TDO_EN).
interface jtag_tap_param_if;
    logic TMS;
    logic TDI;
    logic TDO;
    logic TDO_EN;

    modport master (output TMS, output TDI, input TDO, input TDO_EN);
    modport slave  (input TMS, input TDI, output TDO, output TDO_EN);
endinterface

// File: rtl/jtag_tap_param.sv
// Parametrised 1149.1-style TAP: controller, IR, bypass, optional IDCODE, BSR_LEN-cell boundary scan.
// Latency: capture/shift on TCK rise; TDO, TDO_EN, IR and BSR update stages on the following TCK fall.
// Backpressure: none; progress is paced by TCK/TMS.
// Ports: TCK, TRST_N (async active-low); jtag (slave modport: TMS, TDI, TDO, TDO_EN);
//        data_in/data_out (functional path through the boundary cells); Mode; tap_state (debug).
// Optional feature: define JTAG_IDCODE_EN to add the 32-bit IDCODE register and make it the
// reset instruction; otherwise code 2 decodes as BYPASS and BYPASS is the reset instruction.
module jtag_tap_param #(
    parameter int          IR_W       = 4,
    parameter int          BSR_LEN    = 34,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic               TCK,
    input  logic               TRST_N,
    jtag_tap_param_if.slave    jtag,
    input  logic [BSR_LEN-1:0] data_in,
    output logic [BSR_LEN-1:0] data_out,
    output logic               Mode,
    output logic [3:0]         tap_state
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_t;

    localparam logic [IR_W-1:0] IR_EXTEST  = IR_W'(0);
    localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(1);
    localparam logic [IR_W-1:0] IR_INTEST  = IR_W'(3);
    localparam logic [IR_W-1:0] IR_BYPASS  = '1;
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);  // mandatory ...01 capture pattern
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(2);
    localparam logic [IR_W-1:0] IR_RESET   = IR_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RESET   = IR_BYPASS;
`endif

    // Guard: a legal IDCODE always has bit 0 set so it can be told apart from BYPASS on readout.
    if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_must_be_one
    end

    tap_state_t         state;
    tap_state_t         state_nxt;
    logic [IR_W-1:0]    ir_shift;
    logic [IR_W-1:0]    ir_upd;
    logic               bypass_reg;
    logic [BSR_LEN-1:0] bsr_shift;
    logic [BSR_LEN-1:0] bsr_upd;
`ifdef JTAG_IDCODE_EN
    logic [31:0]        idcode_shift;
    logic               sel_id;
`endif
    logic               sel_bsr;
    logic               sel_bypass;
    logic               tdo_mux;
    logic               shifting;
    logic               tdo_q;
    logic               tdo_en_q;

    // ---------------- TAP controller ----------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) state <= TLR;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = TLR;
        case (state)
            TLR:     state_nxt = jtag.TMS ? TLR    : RTI;
            RTI:     state_nxt = jtag.TMS ? SEL_DR : RTI;
            SEL_DR:  state_nxt = jtag.TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt = jtag.TMS ? EX1_DR : SH_DR;
            SH_DR:   state_nxt = jtag.TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt = jtag.TMS ? UPD_DR : PAU_DR;
            PAU_DR:  state_nxt = jtag.TMS ? EX2_DR : PAU_DR;
            EX2_DR:  state_nxt = jtag.TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt = jtag.TMS ? SEL_DR : RTI;
            SEL_IR:  state_nxt = jtag.TMS ? TLR    : CAP_IR;
            CAP_IR:  state_nxt = jtag.TMS ? EX1_IR : SH_IR;
            SH_IR:   state_nxt = jtag.TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt = jtag.TMS ? UPD_IR : PAU_IR;
            PAU_IR:  state_nxt = jtag.TMS ? EX2_IR : PAU_IR;
            EX2_IR:  state_nxt = jtag.TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt = jtag.TMS ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    assign tap_state = state;

    // ---------------- instruction decode ----------------
    // All-ones is tested first so BYPASS wins even when IR_W is small enough
    // for it to collide with another code.
    always_comb begin
        sel_bsr = 1'b0;
        Mode    = 1'b0;
`ifdef JTAG_IDCODE_EN
        sel_id  = 1'b0;
`endif
        if (ir_upd == IR_BYPASS) begin
            sel_bsr = 1'b0;
        end else if (ir_upd == IR_EXTEST || ir_upd == IR_INTEST) begin
            sel_bsr = 1'b1;
            Mode    = 1'b1;
        end else if (ir_upd == IR_SAMPLE) begin
            sel_bsr = 1'b1;
`ifdef JTAG_IDCODE_EN
        end else if (ir_upd == IR_IDCODE) begin
            sel_id  = 1'b1;
`endif
        end
    end

`ifdef JTAG_IDCODE_EN
    assign sel_bypass = !sel_bsr && !sel_id;
`else
    assign sel_bypass = !sel_bsr;
`endif

    // ---------------- capture / shift stages (TCK rise) ----------------
    // Shifts are written as {TDI, reg} >> 1 so a 1-bit register needs no reversed slice.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_shift     <= '0;
            bypass_reg   <= 1'b0;
            bsr_shift    <= '0;
`ifdef JTAG_IDCODE_EN
            idcode_shift <= '0;
`endif
        end else begin
            case (state)
                CAP_IR: ir_shift <= IR_CAPTURE;
                SH_IR:  ir_shift <= IR_W'({jtag.TDI, ir_shift} >> 1);
                CAP_DR: begin
                    if (sel_bsr)    bsr_shift    <= data_in;
                    if (sel_bypass) bypass_reg   <= 1'b0;
`ifdef JTAG_IDCODE_EN
                    if (sel_id)     idcode_shift <= IDCODE_VAL;
`endif
                end
                SH_DR: begin
                    if (sel_bsr)    bsr_shift    <= BSR_LEN'({jtag.TDI, bsr_shift} >> 1);
                    if (sel_bypass) bypass_reg   <= jtag.TDI;
`ifdef JTAG_IDCODE_EN
                    if (sel_id)     idcode_shift <= {jtag.TDI, idcode_shift[31:1]};
`endif
                end
                default: ;
            endcase
        end
    end

    // ---------------- TDO mux ----------------
    always_comb begin
        tdo_mux  = 1'b0;
        shifting = 1'b0;
        case (state)
            SH_IR: begin
                shifting = 1'b1;
                tdo_mux  = ir_shift[0];
            end
            SH_DR: begin
                shifting = 1'b1;
                if (sel_bsr)         tdo_mux = bsr_shift[0];
`ifdef JTAG_IDCODE_EN
                else if (sel_id)     tdo_mux = idcode_shift[0];
`endif
                else                 tdo_mux = bypass_reg;
            end
            default: ;
        endcase
    end

    // ---------------- update stages and TDO (TCK fall) ----------------
    // BSR update latches survive TLR; only TRST_N clears them.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_upd   <= IR_RESET;
            bsr_upd  <= '0;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            if (state == TLR)         ir_upd <= IR_RESET;
            else if (state == UPD_IR) ir_upd <= ir_shift;
            if (state == UPD_DR && sel_bsr) bsr_upd <= bsr_shift;
            tdo_q    <= tdo_mux;
            tdo_en_q <= shifting;
        end
    end

    assign jtag.TDO    = tdo_q;
    assign jtag.TDO_EN = tdo_en_q;
    assign data_out    = Mode ? bsr_upd : data_in;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Self-checking bench for jtag_tap_param: drives TMS/TDI through tasks, scoreboards TDO bit streams.
// Latency: each step is one full TCK period; outputs are sampled 1 time unit after the TCK fall.
// Backpressure: none.
module tb_jtag_tap_param;
    localparam int IR_W    = 4;
    localparam int BSR_LEN = 34;

    logic               tck    = 1'b0;
    logic               trst_n = 1'b1;
    logic [BSR_LEN-1:0] data_in;
    logic [BSR_LEN-1:0] data_out;
    logic               mode;
    logic [3:0]         tap_state;
    logic               cur_tdo;
    logic               exp_q[$];
    int                 n_cmp = 0;
    int                 n_bad = 0;

    jtag_tap_param_if jif();

    jtag_tap_param #(.IR_W(IR_W), .BSR_LEN(BSR_LEN), .IDCODE_VAL(32'h1000_0001)) dut (
        .TCK       (tck),
        .TRST_N    (trst_n),
        .jtag      (jif),
        .data_in   (data_in),
        .data_out  (data_out),
        .Mode      (mode),
        .tap_state (tap_state)
    );

    always #5 tck = ~tck;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One TCK period: drive, let the rise act, then sample just after the fall.
    task automatic step(input logic tms, input logic tdi);
        jif.TMS = tms;
        jif.TDI = tdi;
        @(posedge tck);
        @(negedge tck);
        #1;
        cur_tdo = jif.TDO;
    endtask

    task automatic push_bits(input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    // One-bit register: first bit out is the captured 0, then TDI delayed by one.
    task automatic push_delayed(input int n, input logic [63:0] v);
        exp_q.push_back(1'b0);
        for (int i = 0; i < n - 1; i++) exp_q.push_back(v[i]);
    endtask

    // Starts in a Shift state; ends in Exit1. Optional 3-cycle pause after bit pause_at.
    task automatic scan(input string tag, input int n, input logic [63:0] din, input int pause_at);
        logic e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) e = 1'bx;
            else                   e = exp_q.pop_front();
            check_val($sformatf("%s bit%0d", tag, i), 64'(cur_tdo), 64'(e));
            if (i == n - 1) begin
                step(1'b1, din[i]);
            end else if (i == pause_at) begin
                step(1'b1, din[i]);
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
                check_val($sformatf("%s pause state", tag), 64'(tap_state), 64'h3);
                step(1'b1, 1'b0);
                step(1'b0, 1'b0);
            end else begin
                step(1'b0, din[i]);
            end
        end
    endtask

    task automatic goto_shdr(input string tag);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val({tag, " ShDR state"}, 64'(tap_state), 64'h2);
        check_val({tag, " ShDR tdo_en"}, 64'(jif.TDO_EN), 64'h1);
    endtask

    task automatic finish_scan();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic ir_scan(input string tag, input logic [IR_W-1:0] instr);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        push_bits(IR_W, 64'h1);
        scan(tag, IR_W, 64'(instr), -1);
        step(1'b1, 1'b0);   // into UpdIR; update stage loads on this fall
    endtask

    initial begin
        jif.TMS = 1'b1;
        jif.TDI = 1'b0;
        data_in = 34'h0_1234_5678;
        cur_tdo = 1'b0;

        // Power-on reset
        #1 trst_n = 1'b0;
        #2;
        check_val("rst state",    64'(tap_state),     64'hF);
        check_val("rst tdo_en",   64'(jif.TDO_EN),    64'h0);
        check_val("rst tdo",      64'(jif.TDO),       64'h0);
        check_val("rst mode",     64'(mode),          64'h0);
        check_val("rst data_out", 64'(data_out),      64'(data_in));
        @(negedge tck);
        #1 trst_n = 1'b1;
        step(1'b0, 1'b0);
        check_val("rti state", 64'(tap_state), 64'hC);

        // Default DR after reset
        goto_shdr("dflt");
`ifdef JTAG_IDCODE_EN
        push_bits(32, 64'h1000_0001);
        scan("idcode", 32, 64'h5A5A_A5A5, -1);
`else
        push_delayed(8, 64'hB5);
        scan("dflt byp", 8, 64'hB5, -1);
`endif
        check_val("exit tdo_en", 64'(jif.TDO_EN), 64'h0);
        finish_scan();

        // EXTEST straight after reset: latches still zero
        ir_scan("ir extest0", 4'b0000);
        check_val("extest0 mode",     64'(mode),     64'h1);
        check_val("extest0 data_out", 64'(data_out), 64'h0);
        step(1'b0, 1'b0);

        // Five TMS=1 rises from ShDR reach TLR
        goto_shdr("tms5");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_val("tms5 state", 64'(tap_state), 64'hF);
        check_val("tms5 mode",  64'(mode),      64'h0);
        step(1'b0, 1'b0);

        // SAMPLE/PRELOAD
        ir_scan("ir sample", 4'b0001);
        step(1'b0, 1'b0);
        check_val("sample mode", 64'(mode), 64'h0);
        data_in = 34'h2_AAAA_5555;
        goto_shdr("sample");
        push_bits(BSR_LEN, 64'(data_in));
        scan("sample bsr", BSR_LEN, 64'h1_0000_FFFF, -1);
        finish_scan();
        check_val("sample data_out", 64'(data_out), 64'h2_AAAA_5555);
        data_in = 34'h0_0F0F_F0F0;
        #1;
        check_val("sample follow", 64'(data_out), 64'h0_0F0F_F0F0);

        // EXTEST drives the preloaded value
        ir_scan("ir extest", 4'b0000);
        check_val("extest mode",     64'(mode),     64'h1);
        check_val("extest data_out", 64'(data_out), 64'h1_0000_FFFF);
        data_in = ~data_in;
        #1;
        check_val("extest hold", 64'(data_out), 64'h1_0000_FFFF);
        step(1'b0, 1'b0);

        // TLR restores reset instruction but keeps the update latches
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_val("tlr mode", 64'(mode), 64'h0);
        step(1'b0, 1'b0);
        ir_scan("ir extest2", 4'b0000);
        check_val("tlr keeps latch", 64'(data_out), 64'h1_0000_FFFF);
        step(1'b0, 1'b0);

        // TRST_N mid-scan
        goto_shdr("trst");
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        #1 trst_n = 1'b0;
        #1;
        check_val("trst state",    64'(tap_state),  64'hF);
        check_val("trst tdo_en",   64'(jif.TDO_EN), 64'h0);
        check_val("trst mode",     64'(mode),       64'h0);
        check_val("trst data_out", 64'(data_out),   64'(data_in));
        @(negedge tck);
        #1 trst_n = 1'b1;
        step(1'b0, 1'b0);
        ir_scan("ir extest3", 4'b0000);
        check_val("trst clears latch", 64'(data_out), 64'h0);
        step(1'b0, 1'b0);

        // BYPASS and an undefined code, each with a mid-scan pause
        ir_scan("ir bypass", 4'b1111);
        step(1'b0, 1'b0);
        check_val("bypass mode", 64'(mode), 64'h0);
        goto_shdr("bypass");
        push_delayed(12, 64'hD3B);
        scan("bypass dr", 12, 64'hD3B, 5);
        finish_scan();

        ir_scan("ir undef", 4'b0110);
        step(1'b0, 1'b0);
        goto_shdr("undef");
        push_delayed(12, 64'h5C6);
        scan("undef dr", 12, 64'h5C6, 3);
        finish_scan();

        check_val("queue drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jtag_tap_param.md
# jtag_tap_param

Parametrised IEEE 1149.1-style test access port. It combines the 16-state TAP controller, an IR_W-bit instruction register with decoder, and a bypass register. It also includes an optional 32-bit IDCODE register and a BSR_LEN-cell boundary-scan register with capture, shift and update stages. It sits between the chip-level JTAG pins and the core's functional I/O. It replaces the fixed-width adder-specific scan wrapper with a generic, width-configurable one.

## Interface
- IR_W, 4: instruction register width; minimum 2.
- BSR_LEN, 34: number of boundary-scan cells; minimum 1.
- IDCODE_VAL, 32'h1000_0001: IDCODE value; bit 0 must be 1.
- TCK  in  1  test clock; all state is clocked by TCK.
- TRST_N  in  1  asynchronous, active-low reset.
- TMS  in  1  mode select, sampled on TCK rise.
- TDI  in  1  serial data in, sampled on TCK rise.
- TDO  out  1  serial data out, driven on TCK fall; 0 when TDO_EN=0.
- TDO_EN  out  1  output enable for the pad tristate; high only while shifting.
- data_in  in  BSR_LEN  functional values arriving at boundary cells (pin or core side).
- data_out  out  BSR_LEN  per cell: Mode ? update latch : data_in.
- Mode  out  1  1 when the active instruction is EXTEST or INTEST.
- tap_state  out  4  current TAP state encoding, for debug and verification.

## Operation
- FSM uses the 16 standard states with standard TMS transitions.
- Encodings: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
- Instructions (IR_W bits, zero-extended):
  - EXTEST = 0: BSR selected, Mode=1.
  - SAMPLE/PRELOAD = 1: BSR selected, Mode=0.
  - IDCODE = 2: IDCODE register selected.
  - INTEST = 3: BSR selected, Mode=1.
  - All-ones = BYPASS.
  - Any other code is decoded as BYPASS.
- IR has a shift stage and an update stage.
  - CapIR: shift stage loads {0..0, 2'b01}.
  - ShIR: shifts right, TDI enters the MSB, LSB goes out.
  - UpdIR: update stage loads the shift stage.
- Data registers capture in CapDR, shift right in ShDR (TDI into the MSB), and load their update stage in UpdDR.
  - BSR capture: data_in. BSR update drives the update latches.
  - BYPASS capture: 0, 1 bit.
  - IDCODE capture: IDCODE_VAL, 32 bits.
- TDO mux: IR LSB in ShIR, selected DR LSB in ShDR; otherwise TDO is don't-care and gated to 0.
- TLR is entered asynchronously by TRST_N=0, or synchronously after 5 TCK rises with TMS=1 from any state.
  - In TLR: update IR = reset instruction, Mode=0.
  - BSR update latches are not cleared by TLR, only by TRST_N.

## Timing
- TRST_N low (asynchronous), all forced immediately:
  - state=TLR;
  - IR update stage = reset instruction;
  - IR shift stage = 0, BSR shift/update = 0, bypass = 0;
  - TDO=0, TDO_EN=0, Mode=0;
  - data_out = data_in.
- TRST_N deassertion mid-scan: controller restarts in TLR; no partial shift is applied.
- State register, capture and shift act on the TCK rising edge.
- Update stages (IR and BSR) load on the TCK falling edge while in UpdIR/UpdDR.
  - Mode and data_out change half a cycle after the UpdIR/UpdDR rise.
- TDO and TDO_EN are registered on the TCK falling edge.
  - Value = mux output for the state entered at the preceding rise.
  - First shifted-out bit is valid on the fall after entering ShDR/ShIR.
- Pause/Exit states hold all shift contents.
- Re-entering ShDR/ShIR resumes shifting without recapture.
- Instruction change takes effect on the UpdIR falling edge. A DR scan started after it uses the new selection.
- Shifting more than the register length passes TDI through with the register-length delay; there is no wrap or error.

## Configuration
- JTAG_IDCODE_EN defined:
  - IDCODE register present;
  - reset instruction = IDCODE (2);
  - code 2 selects IDCODE.
- JTAG_IDCODE_EN undefined:
  - no IDCODE register;
  - reset instruction = BYPASS (all ones);
  - code 2 decodes as BYPASS.

## Test plan
- TRST_N=0 at arbitrary state -> tap_state=F, TDO_EN=0, Mode=0, data_out==data_in; TMS=1 for 5 rises from ShDR -> tap_state=F.
- IR scan, IR_W=4: shift in 4'b0000 -> 4'b0001 is shifted out (capture pattern), then after UpdIR fall Mode=1 and data_out equals the last BSR update (0 after reset).
- With JTAG_IDCODE_EN: reset, go to ShDR, shift 32 bits -> TDO sequence LSB-first equals 32'h1000_0001. Without the macro -> single 0 then TDI delayed 1 bit.
- SAMPLE/PRELOAD with data_in=34'h2_AAAA_5555: DR scan of 34 bits -> TDO returns 34'h2_AAAA_5555 LSB-first. The shifted-in 34'h1_0000_FFFF is held in the update latches, and data_out still equals data_in.
- EXTEST after that preload -> data_out=34'h1_0000_FFFF on the UpdIR fall, independent of data_in toggling.
- BYPASS (4'b1111) and an undefined code 4'b0110 -> DR scan shows TDO = TDI delayed by exactly 1 TCK, first bit 0. Pause-DR for 3 cycles mid-scan -> sequence unbroken.
